// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC I/O target front end: FSM state encoding,
// LPC cycle-type and protocol nibble values, and the window-hit helper.
package lpc_pkg;

   // Target FSM states; encodings kept fixed for waveform compatibility
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CYC  = 3'd1,
      ST_ADR  = 3'd2,
      ST_WDAT = 3'd3,
      ST_HTAR = 3'd4,
      ST_SYNC = 3'd5,
      ST_RDAT = 3'd6,
      ST_PTAR = 3'd7
   } lpcState_t;

   // CYCTYPE + DIR nibble values decoded by this target
   localparam logic [3:0] LPC_IO_RD    = 4'b0000;
   localparam logic [3:0] LPC_IO_WR    = 4'b0010;

   // Protocol nibbles
   localparam logic [3:0] LPC_START    = 4'h0;
   localparam logic [3:0] LPC_SYNC_RDY = 4'h0;
   localparam logic [3:0] LPC_TAR      = 4'hF;

   // Window hit: upper 11 address bits match, low 5 bits select the register
   function automatic logic addrHit(input logic [10:0] addrHi,
                                    input logic [10:0] baseHi);
      return addrHi == baseHi;
   endfunction

endpackage

// File: rtl/lpc_io_decoder.sv
// LPC I/O target front end. Decodes host I/O read/write cycles that hit a
// 32-byte window at BASE_ADDR and answers with SYNC, TAR and read data.
// Presents a register offset plus one-clock Wr/Rd strobes to the register
// file. The LAD pad tristate is built one level up from LadOut/LadOe.
module lpc_io_decoder
   import lpc_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0800
) (
   input  logic       LpcClock,
   input  logic       PciReset,
   input  logic       LFRAME_N,
   input  logic [3:0] LadIn,
   output logic [3:0] LadOut,
   output logic       LadOe,
   input  logic [7:0] RdData,
   output logic [7:0] Addr,
   output logic       Wr,
   output logic [7:0] DataWrSW,
   output logic       Rd
);

   lpcState_t   state;
   logic [1:0]  nibCnt;
   logic        isWrite;
   logic [11:0] addrSh;
   logic [7:0]  wrSh;
   logic [7:0]  rdSh;
   logic        frameAbort;

   // LFRAME# low outside IDLE terminates whatever cycle is in flight
   assign frameAbort = (state != ST_IDLE) && !LFRAME_N;

   // Protocol sequencer; every output is registered here
   always_ff @(posedge LpcClock) begin
      if (PciReset) begin
         state    <= ST_IDLE;
         nibCnt   <= '0;
         isWrite  <= 1'b0;
         addrSh   <= '0;
         wrSh     <= '0;
         rdSh     <= '0;
         LadOe    <= 1'b0;
         LadOut   <= LPC_TAR;
         Addr     <= '0;
         Wr       <= 1'b0;
         DataWrSW <= '0;
         Rd       <= 1'b0;
      end else begin
         Wr <= 1'b0;
         Rd <= 1'b0;
         if (frameAbort) begin
            LadOe  <= 1'b0;
            LadOut <= LPC_TAR;
            nibCnt <= '0;
            state  <= (LadIn == LPC_START) ? ST_CYC : ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (!LFRAME_N && (LadIn == LPC_START))
                     state <= ST_CYC;
               end

               ST_CYC: begin
                  nibCnt <= '0;
                  if (LadIn == LPC_IO_RD) begin
                     isWrite <= 1'b0;
                     state   <= ST_ADR;
                  end else if (LadIn == LPC_IO_WR) begin
                     isWrite <= 1'b1;
                     state   <= ST_ADR;
                  end else begin
                     state   <= ST_IDLE;
                  end
               end

               ST_ADR: begin
                  addrSh <= {addrSh[7:0], LadIn};
                  nibCnt <= nibCnt + 2'd1;
                  if (nibCnt == 2'd3) begin
                     nibCnt <= '0;
                     // Full address is {addrSh, LadIn}; A[15:5] is addrSh[11:1]
                     if (addrHit(addrSh[11:1], BASE_ADDR[15:5])) begin
                        Addr  <= {3'b000, addrSh[0], LadIn};
                        state <= isWrite ? ST_WDAT : ST_HTAR;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end
               end

               ST_WDAT: begin
                  if (nibCnt == 2'd0) begin
                     wrSh[3:0] <= LadIn;
                     nibCnt    <= 2'd1;
                  end else begin
                     wrSh[7:4] <= LadIn;
                     nibCnt    <= '0;
                     state     <= ST_HTAR;
                  end
               end

               ST_HTAR: begin
                  if (nibCnt == 2'd0) begin
                     nibCnt <= 2'd1;
                  end else begin
                     nibCnt <= '0;
                     LadOe  <= 1'b1;
                     LadOut <= LPC_SYNC_RDY;
                     state  <= ST_SYNC;
                     if (isWrite) begin
                        Wr       <= 1'b1;
                        DataWrSW <= wrSh;
                     end else begin
                        Rd   <= 1'b1;
                        rdSh <= RdData;
                     end
                  end
               end

               ST_SYNC: begin
                  nibCnt <= '0;
                  if (isWrite) begin
                     LadOut <= LPC_TAR;
                     state  <= ST_PTAR;
                  end else begin
                     LadOut <= rdSh[3:0];
                     state  <= ST_RDAT;
                  end
               end

               ST_RDAT: begin
                  if (nibCnt == 2'd0) begin
                     LadOut <= rdSh[7:4];
                     nibCnt <= 2'd1;
                  end else begin
                     LadOut <= LPC_TAR;
                     nibCnt <= '0;
                     state  <= ST_PTAR;
                  end
               end

               ST_PTAR: begin
                  // F was driven on the clock entering PTAR; release now
                  LadOe  <= 1'b0;
                  LadOut <= LPC_TAR;
                  nibCnt <= '0;
                  state  <= ST_IDLE;
               end

               default: begin
                  LadOe  <= 1'b0;
                  LadOut <= LPC_TAR;
                  state  <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lpc_io_decoder.sv
// Directed bench for lpc_io_decoder: table of LPC I/O cycles with
// hand-computed responses, plus abort and mid-cycle reset sequences.
module tb_lpc_io_decoder;
   import lpc_pkg::*;

   logic       LpcClock = 1'b0;
   logic       PciReset;
   logic       LFRAME_N;
   logic [3:0] LadIn;
   logic [3:0] LadOut;
   logic       LadOe;
   logic [7:0] RdData;
   logic [7:0] Addr;
   logic       Wr;
   logic [7:0] DataWrSW;
   logic       Rd;

   always #15 LpcClock = ~LpcClock;

   lpc_io_decoder #(.BASE_ADDR(16'h0800)) dut (
      .LpcClock (LpcClock),
      .PciReset (PciReset),
      .LFRAME_N (LFRAME_N),
      .LadIn    (LadIn),
      .LadOut   (LadOut),
      .LadOe    (LadOe),
      .RdData   (RdData),
      .Addr     (Addr),
      .Wr       (Wr),
      .DataWrSW (DataWrSW),
      .Rd       (Rd)
   );

   typedef struct {
      logic [3:0]  cyc;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  rdData;
      logic        expHit;
   } vec_t;

   int checks   = 0;
   int failures = 0;
   int wrCnt    = 0;
   int rdCnt    = 0;
   int bothCnt  = 0;
   logic [7:0] expAddr;
   logic [7:0] expData;

   // Strobe tally, sampled mid-cycle
   always @(negedge LpcClock) begin
      if (Wr) wrCnt++;
      if (Rd) rdCnt++;
      if (Wr && Rd) bothCnt++;
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge LpcClock);
      #1;
   endtask

   // START, CYCTYPE and four address nibbles (edges n..n+5)
   task automatic sendHeader(input logic [3:0] cyc, input logic [15:0] a);
      LFRAME_N = 1'b0; LadIn = LPC_START; step();
      LFRAME_N = 1'b1; LadIn = cyc;       step();
      for (int i = 3; i >= 0; i--) begin
         LadIn = a[i*4 +: 4];
         step();
      end
   endtask

   task automatic doCycle(input vec_t v, input string nm);
      int   w0, r0;
      logic isWr;
      logic seenOe;
      w0     = wrCnt;
      r0     = rdCnt;
      isWr   = (v.cyc == LPC_IO_WR);
      seenOe = 1'b0;
      RdData = v.rdData;
      sendHeader(v.cyc, v.addr);
      if (v.expHit) expAddr = {3'b000, v.addr[4:0]};
      chk({nm, "_addr"}, {8'h00, Addr}, {8'h00, expAddr});
      if (v.expHit && isWr) begin
         LadIn = v.wdata[3:0]; step();
         LadIn = v.wdata[7:4]; step();
         LadIn = 4'hF;         step();
         chk({nm, "_htarOe"}, {15'd0, LadOe}, 16'd0);
         step();
         expData = v.wdata;
         chk({nm, "_syncOe"},  {15'd0, LadOe}, 16'd1);
         chk({nm, "_syncLad"}, {12'd0, LadOut}, 16'h0);
         chk({nm, "_wr"},      {15'd0, Wr}, 16'd1);
         chk({nm, "_wdata"},   {8'd0, DataWrSW}, {8'd0, v.wdata});
         step();
         chk({nm, "_tarLad"},  {12'd0, LadOut}, 16'hF);
         chk({nm, "_tarOe"},   {15'd0, LadOe}, 16'd1);
         chk({nm, "_wrOff"},   {15'd0, Wr}, 16'd0);
         step();
         chk({nm, "_release"}, {15'd0, LadOe}, 16'd0);
      end else if (v.expHit) begin
         LadIn = 4'hF; step();
         chk({nm, "_htarOe"}, {15'd0, LadOe}, 16'd0);
         step();
         chk({nm, "_syncOe"},  {15'd0, LadOe}, 16'd1);
         chk({nm, "_syncLad"}, {12'd0, LadOut}, 16'h0);
         chk({nm, "_rd"},      {15'd0, Rd}, 16'd1);
         RdData = ~v.rdData;   // data must already be captured
         step();
         chk({nm, "_lo"},      {12'd0, LadOut}, {12'd0, v.rdData[3:0]});
         chk({nm, "_rdOff"},   {15'd0, Rd}, 16'd0);
         step();
         chk({nm, "_hi"},      {12'd0, LadOut}, {12'd0, v.rdData[7:4]});
         step();
         chk({nm, "_tarLad"},  {12'd0, LadOut}, 16'hF);
         chk({nm, "_tarOe"},   {15'd0, LadOe}, 16'd1);
         step();
         chk({nm, "_release"}, {15'd0, LadOe}, 16'd0);
      end else begin
         LadIn = 4'hF;
         repeat (8) begin
            step();
            if (LadOe) seenOe = 1'b1;
         end
         chk({nm, "_noDrive"}, {15'd0, seenOe}, 16'd0);
      end
      chk({nm, "_dataHold"}, {8'd0, DataWrSW}, {8'd0, expData});
      step();
      chk({nm, "_wrCount"}, 16'(wrCnt - w0), (v.expHit && isWr)  ? 16'd1 : 16'd0);
      chk({nm, "_rdCount"}, 16'(rdCnt - r0), (v.expHit && !isWr) ? 16'd1 : 16'd0);
   endtask

   vec_t vecs [8];

   initial begin
      int w0;
      vecs[0] = '{LPC_IO_WR, 16'h0809, 8'hA5, 8'h00, 1'b1};
      vecs[1] = '{LPC_IO_RD, 16'h0801, 8'h00, 8'h55, 1'b1};
      vecs[2] = '{LPC_IO_RD, 16'h0900, 8'h00, 8'h77, 1'b0};
      vecs[3] = '{4'b0100,   16'h0800, 8'h00, 8'h11, 1'b0};
      vecs[4] = '{LPC_IO_WR, 16'h0804, 8'h3C, 8'h00, 1'b1};
      vecs[5] = '{LPC_IO_RD, 16'h081F, 8'h00, 8'hC3, 1'b1};
      vecs[6] = '{LPC_IO_WR, 16'h07FF, 8'h99, 8'h00, 1'b0};
      vecs[7] = '{LPC_IO_RD, 16'h0820, 8'h00, 8'hE1, 1'b0};

      PciReset = 1'b1; LFRAME_N = 1'b1; LadIn = 4'hF; RdData = 8'h00;
      step(); step();
      PciReset = 1'b0;
      chk("rst_oe",   {15'd0, LadOe}, 16'd0);
      chk("rst_lad",  {12'd0, LadOut}, 16'hF);
      chk("rst_addr", {8'd0, Addr}, 16'd0);
      chk("rst_wr",   {15'd0, Wr}, 16'd0);
      chk("rst_data", {8'd0, DataWrSW}, 16'd0);
      chk("rst_rd",   {15'd0, Rd}, 16'd0);
      expAddr = 8'h00;
      expData = 8'h00;
      step();

      for (int i = 0; i < 8; i++)
         doCycle(vecs[i], $sformatf("v%0d", i));

      // Abort during WDAT with a new START, then back-to-back read
      w0 = wrCnt;
      sendHeader(LPC_IO_WR, 16'h0808);
      expAddr = 8'h08;
      LadIn = 4'h6; step();
      LFRAME_N = 1'b0; LadIn = LPC_START; step();
      chk("abort_oe",  {15'd0, LadOe}, 16'd0);
      chk("abort_lad", {12'd0, LadOut}, 16'hF);
      chk("abort_wr",  {15'd0, Wr}, 16'd0);
      doCycle('{LPC_IO_RD, 16'h081F, 8'h00, 8'h96, 1'b1}, "b2bRead");
      chk("abort_noWr", 16'(wrCnt - w0), 16'd0);

      // Reset pulse while SYNC is being driven on a read
      RdData = 8'h3A;
      sendHeader(LPC_IO_RD, 16'h0801);
      LadIn = 4'hF; step(); step();
      chk("rstSync_oe", {15'd0, LadOe}, 16'd1);
      chk("rstSync_rd", {15'd0, Rd}, 16'd1);
      PciReset = 1'b1; step();
      PciReset = 1'b0;
      chk("rstMid_oe",   {15'd0, LadOe}, 16'd0);
      chk("rstMid_lad",  {12'd0, LadOut}, 16'hF);
      chk("rstMid_addr", {8'd0, Addr}, 16'd0);
      chk("rstMid_wr",   {15'd0, Wr}, 16'd0);
      chk("rstMid_data", {8'd0, DataWrSW}, 16'd0);
      chk("rstMid_rd",   {15'd0, Rd}, 16'd0);
      expAddr = 8'h00;
      expData = 8'h00;
      step();
      doCycle('{LPC_IO_WR, 16'h0803, 8'h5A, 8'h00, 1'b1}, "postRst");

      chk("neverBoth", 16'(bothCnt), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
